// File: rtl/acl_kmem_arbiter_2to1.sv
// Two-master arbiter in front of kernel_mem0. Master 0 (k_) is the kernel
// interconnect and master 1 (v_) is the VGA frame reader. Commands pass
// through combinationally. Write bursts lock the grant to the bursting master.
// Read responses are routed in order using an owner FIFO.
module acl_kmem_arbiter_2to1 #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 256,
  parameter int BURST_W     = 5,
  parameter int MAX_PENDING = 8,
  parameter bit M1_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     k_address,
  input  logic                  k_read,
  input  logic                  k_write,
  input  logic [DATA_W-1:0]     k_writedata,
  input  logic [DATA_W/8-1:0]   k_byteenable,
  input  logic [BURST_W-1:0]    k_burstcount,
  output logic                  k_waitrequest,
  output logic [DATA_W-1:0]     k_readdata,
  output logic                  k_readdatavalid,
  input  logic [ADDR_W-1:0]     v_address,
  input  logic                  v_read,
  input  logic                  v_write,
  input  logic [DATA_W-1:0]     v_writedata,
  input  logic [DATA_W/8-1:0]   v_byteenable,
  input  logic [BURST_W-1:0]    v_burstcount,
  output logic                  v_waitrequest,
  output logic [DATA_W-1:0]     v_readdata,
  output logic                  v_readdatavalid,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  output logic [BURST_W-1:0]    s_burstcount,
  output logic                  s_debugaccess,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,
  output logic                  err_rdv_unexpected
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_WBURST = 1'b1;

  logic [0:0]             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   wr_owner_q, wr_owner_d;
  logic [BURST_W-1:0]     wr_remaining_q, wr_remaining_d;
  logic [MAX_PENDING-1:0] fifo_owner_q, fifo_owner_d;
  logic [BURST_W-1:0]     fifo_bc_q [MAX_PENDING];
  logic [BURST_W-1:0]     fifo_bc_d [MAX_PENDING];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic [BURST_W-1:0]     rd_beats_q, rd_beats_d;
  logic                   err_q, err_d;

  logic                   k_req, v_req, grant;
  logic                   sel_read, sel_write, fifo_full, fifo_empty;
  logic                   issue_read, issue_write, grant_wait, accepted, push;
  logic [BURST_W-1:0]     sel_bc, sel_bc_eff, head_bc, rd_beats_inc;
  logic                   head_owner, rsp_valid, rsp_pop;

  // Pick the master that owns the slave port this cycle.
  always_comb begin
    k_req = k_read | k_write;
    v_req = v_read | v_write;
    grant = 1'b0;
    if (state_q == ST_WBURST) begin
      grant = wr_owner_q;
    end else if (k_req && v_req) begin
      grant = M1_PRIORITY ? 1'b1 : ~last_grant_q;
    end else if (v_req) begin
      grant = 1'b1;
    end
  end

  // Qualify the granted command. Reads are held back while the owner FIFO is full or a write burst is in progress.
  always_comb begin
    sel_read   = grant ? v_read : k_read;
    sel_write  = grant ? v_write : k_write;
    sel_bc     = grant ? v_burstcount : k_burstcount;
    sel_bc_eff = (sel_bc == '0) ? BURST_W'(1) : sel_bc;
    fifo_full  = (count_q == (PTR_W+1)'(MAX_PENDING));
    fifo_empty = (count_q == '0);
    if (state_q == ST_WBURST) begin
      issue_read = 1'b0;
      grant_wait = s_waitrequest | sel_read;
    end else begin
      issue_read = sel_read & ~fifo_full;
      grant_wait = s_waitrequest | (sel_read & fifo_full);
    end
    issue_write = sel_write;
    accepted    = reset_n & (issue_read | issue_write) & ~s_waitrequest;
  end

  assign s_read        = reset_n & issue_read;
  assign s_write       = reset_n & issue_write;
  assign s_address     = grant ? v_address : k_address;
  assign s_writedata   = grant ? v_writedata : k_writedata;
  assign s_byteenable  = grant ? v_byteenable : k_byteenable;
  assign s_burstcount  = sel_bc;
  assign s_debugaccess = 1'b0;
  assign k_waitrequest = ~reset_n | (grant ? 1'b1 : grant_wait);
  assign v_waitrequest = ~reset_n | (grant ? grant_wait : 1'b1);

  // Find which master owns the read beat now returning from the slave.
  always_comb begin
    head_owner   = fifo_owner_q[rd_ptr_q];
    head_bc      = fifo_bc_q[rd_ptr_q];
    rd_beats_inc = rd_beats_q + BURST_W'(1);
    rsp_valid    = s_readdatavalid & ~fifo_empty;
    rsp_pop      = rsp_valid & (rd_beats_inc == head_bc);
  end

  assign k_readdata         = s_readdata;
  assign v_readdata         = s_readdata;
  assign k_readdatavalid    = reset_n & rsp_valid & ~head_owner;
  assign v_readdatavalid    = reset_n & rsp_valid & head_owner;
  assign err_rdv_unexpected = err_q;

  // Update the round-robin pointer and enter or leave a write burst lock.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    wr_owner_d     = wr_owner_q;
    wr_remaining_d = wr_remaining_q;
    if (accepted) begin
      last_grant_d = grant;
      if (state_q == ST_ARB) begin
        if (issue_write && (sel_bc_eff != BURST_W'(1))) begin
          state_d        = ST_WBURST;
          wr_owner_d     = grant;
          wr_remaining_d = sel_bc_eff - BURST_W'(1);
        end
      end else begin
        wr_remaining_d = wr_remaining_q - BURST_W'(1);
        if (wr_remaining_q == BURST_W'(1)) begin
          state_d = ST_ARB;
        end
      end
    end
  end

  // Push issued reads into the owner FIFO and pop them when their last beat returns.
  always_comb begin
    fifo_owner_d = fifo_owner_q;
    fifo_bc_d    = fifo_bc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rd_beats_d   = rd_beats_q;
    err_d        = err_q | (s_readdatavalid & fifo_empty);
    push         = accepted & issue_read;
    if (push) begin
      fifo_owner_d[wr_ptr_q] = grant;
      fifo_bc_d[wr_ptr_q]    = sel_bc_eff;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (rsp_pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rd_beats_d = '0;
    end else if (rsp_valid) begin
      rd_beats_d = rd_beats_inc;
    end
    case ({push, rsp_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset discards all burst and read tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_ARB;
      last_grant_q   <= 1'b1;
      wr_owner_q     <= 1'b0;
      wr_remaining_q <= '0;
      fifo_owner_q   <= '0;
      for (int i = 0; i < MAX_PENDING; i++) fifo_bc_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_beats_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wr_owner_q     <= wr_owner_d;
      wr_remaining_q <= wr_remaining_d;
      fifo_owner_q   <= fifo_owner_d;
      fifo_bc_q      <= fifo_bc_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_beats_q     <= rd_beats_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: tb/tb_acl_kmem_arbiter_2to1.sv
// Self-checking bench for acl_kmem_arbiter_2to1 (round-robin mode, 8 pending reads).
module tb_acl_kmem_arbiter_2to1;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 256;
  localparam int BURST_W = 5;
  localparam int MAX_PENDING = 8;
  localparam int BE_W = DATA_W / 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [ADDR_W-1:0] k_address, v_address, s_address;
  logic k_read, k_write, v_read, v_write, s_read, s_write;
  logic [DATA_W-1:0] k_writedata, v_writedata, s_writedata;
  logic [BE_W-1:0] k_byteenable, v_byteenable, s_byteenable;
  logic [BURST_W-1:0] k_burstcount, v_burstcount, s_burstcount;
  logic k_waitrequest, v_waitrequest, k_readdatavalid, v_readdatavalid;
  logic [DATA_W-1:0] k_readdata, v_readdata, s_readdata;
  logic s_debugaccess, s_waitrequest, s_readdatavalid, err_rdv_unexpected;

  always #5 clk = ~clk;

  acl_kmem_arbiter_2to1 #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_PENDING(MAX_PENDING), .M1_PRIORITY(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .k_address(k_address), .k_read(k_read), .k_write(k_write),
    .k_writedata(k_writedata), .k_byteenable(k_byteenable), .k_burstcount(k_burstcount),
    .k_waitrequest(k_waitrequest), .k_readdata(k_readdata), .k_readdatavalid(k_readdatavalid),
    .v_address(v_address), .v_read(v_read), .v_write(v_write),
    .v_writedata(v_writedata), .v_byteenable(v_byteenable), .v_burstcount(v_burstcount),
    .v_waitrequest(v_waitrequest), .v_readdata(v_readdata), .v_readdatavalid(v_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
    .s_debugaccess(s_debugaccess), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_rdv_unexpected(err_rdv_unexpected)
  );

  int total = 0;
  int bad = 0;
  int k_rdv_cnt = 0;
  int v_rdv_cnt = 0;
  int acc_log[$];
  logic [31:0] data_ctr = 32'h0;

  // Reference model state: who won last, write lock, and the queue of outstanding reads.
  typedef struct { int owner; int beats; } rd_t;
  rd_t m_q[$];
  int m_last = 1;
  int m_lock = 0;
  int m_lock_owner = 0;
  int m_lock_left = 0;
  int m_got = 0;
  int m_err = 0;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, followed by the model's step for the coming edge.
  always @(negedge clk) begin : compare_proc
    int w, bc;
    bit kreq, vreq, rd, wr, full, e_read, e_write, gw, e_krdv, e_vrdv;
    if (!reset_n) begin
      checkOutput("rst_s_read", s_read, 1'b0);
      checkOutput("rst_s_write", s_write, 1'b0);
      checkOutput("rst_k_wait", k_waitrequest, 1'b1);
      checkOutput("rst_v_wait", v_waitrequest, 1'b1);
      checkOutput("rst_k_rdv", k_readdatavalid, 1'b0);
      checkOutput("rst_v_rdv", v_readdatavalid, 1'b0);
      checkOutput("rst_err", err_rdv_unexpected, 1'b0);
      m_q.delete();
      m_last = 1; m_lock = 0; m_lock_owner = 0; m_lock_left = 0; m_got = 0; m_err = 0;
    end else begin
      kreq = k_read || k_write;
      vreq = v_read || v_write;
      if (m_lock != 0) w = m_lock_owner;
      else if (kreq && vreq) w = 1 - m_last;
      else if (vreq) w = 1;
      else w = 0;
      rd = (w == 1) ? v_read : k_read;
      wr = (w == 1) ? v_write : k_write;
      full = (m_q.size() >= MAX_PENDING);
      e_write = wr;
      e_read = (m_lock == 0) && rd && !full;
      gw = s_waitrequest || (rd && ((m_lock != 0) || full));
      checkOutput("s_read", s_read, e_read);
      checkOutput("s_write", s_write, e_write);
      checkOutput("k_wait", k_waitrequest, (w == 0) ? gw : 1'b1);
      checkOutput("v_wait", v_waitrequest, (w == 1) ? gw : 1'b1);
      if (e_read || e_write) begin
        checkOutput("s_address", s_address, (w == 1) ? v_address : k_address);
        checkOutput("s_burstcount", s_burstcount, (w == 1) ? v_burstcount : k_burstcount);
        checkOutput("s_byteenable", s_byteenable, (w == 1) ? v_byteenable : k_byteenable);
      end
      if (e_write) checkOutput("s_writedata", s_writedata, (w == 1) ? v_writedata : k_writedata);
      e_krdv = 1'b0;
      e_vrdv = 1'b0;
      if (s_readdatavalid && (m_q.size() > 0)) begin
        if (m_q[0].owner == 0) e_krdv = 1'b1;
        else e_vrdv = 1'b1;
      end
      checkOutput("k_rdv", k_readdatavalid, e_krdv);
      checkOutput("v_rdv", v_readdatavalid, e_vrdv);
      checkOutput("err", err_rdv_unexpected, (m_err != 0));
      checkOutput("debugaccess", s_debugaccess, 1'b0);
      if (s_readdatavalid) begin
        checkOutput("k_readdata", k_readdata, s_readdata);
        checkOutput("v_readdata", v_readdata, s_readdata);
      end
      if (k_readdatavalid) k_rdv_cnt++;
      if (v_readdatavalid) v_rdv_cnt++;
      if ((s_read || s_write) && !s_waitrequest) acc_log.push_back(k_waitrequest ? 1 : 0);
      if (s_readdatavalid) begin
        if (m_q.size() == 0) m_err = 1;
        else begin
          m_got++;
          if (m_got == m_q[0].beats) begin
            void'(m_q.pop_front());
            m_got = 0;
          end
        end
      end
      if ((e_read || e_write) && !s_waitrequest) begin
        m_last = w;
        bc = int'((w == 1) ? v_burstcount : k_burstcount);
        if (bc == 0) bc = 1;
        if (e_read) m_q.push_back('{w, bc});
        else if (m_lock != 0) begin
          m_lock_left--;
          if (m_lock_left == 0) m_lock = 0;
        end else if (bc > 1) begin
          m_lock = 1; m_lock_owner = w; m_lock_left = bc - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    data_ctr = data_ctr + 32'd1;
    s_readdata = {8{data_ctr}};
  endtask

  task automatic applyStimulus(input logic kr, input logic kw, input logic vr, input logic vw,
                               input logic sw, input logic srv);
    k_read = kr; k_write = kw; v_read = vr; v_write = vw;
    s_waitrequest = sw; s_readdatavalid = srv;
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int k0, v0;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    reset_n = 1'b0;
    k_address = '0; v_address = '0;
    k_writedata = {8{32'hA5A5_0000}}; v_writedata = {8{32'h5A5A_FFFF}};
    k_byteenable = '1; v_byteenable = {16{2'b01}};
    k_burstcount = 5'd1; v_burstcount = 5'd1;
    s_readdata = '0;
    applyStimulus(1, 0, 0, 1, 0, 0);
    #3;
    checkOutput("reset_gate_s_read", s_read, 1'b0);
    checkOutput("reset_gate_s_write", s_write, 1'b0);
    checkOutput("reset_k_wait", k_waitrequest, 1'b1);
    checkOutput("reset_v_wait", v_waitrequest, 1'b1);
    checkOutput("reset_err", err_rdv_unexpected, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    // Single master read, four beats returned after three idle cycles.
    k0 = k_rdv_cnt; v0 = v_rdv_cnt;
    k_address = 25'h0001000; k_burstcount = 5'd4;
    applyStimulus(1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); repeat (3) tick();
    applyStimulus(0, 0, 0, 0, 0, 1); repeat (4) tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("t1_k_beats", k_rdv_cnt - k0, 4);
    checkOutput("t1_v_beats", v_rdv_cnt - v0, 0);

    // Contention after reset alternates starting with master 0.
    applyReset();
    acc_log.delete();
    k0 = k_rdv_cnt; v0 = v_rdv_cnt;
    k_address = 25'h10; v_address = 25'h20; k_burstcount = 5'd1; v_burstcount = 5'd1;
    applyStimulus(1, 0, 1, 0, 0, 0); repeat (4) tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("t2_accept_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_log.size()) checkOutput("t2_order", acc_log[i], exp_order[i]);
    end
    applyStimulus(0, 0, 0, 0, 0, 1); repeat (4) tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("t2_k_beats", k_rdv_cnt - k0, 2);
    checkOutput("t2_v_beats", v_rdv_cnt - v0, 2);

    // Write burst of 8 with a toggling slave stall locks out master 1's read.
    k_address = 25'h400; k_burstcount = 5'd8; v_address = 25'h800; v_burstcount = 5'd1;
    for (int c = 0; c < 15; c++) begin
      k_writedata = {8{32'(c / 2)}};
      applyStimulus(0, 1, 1, 0, logic'(c % 2), 0);
      #2;
      checkOutput("t3_v_locked_out", v_waitrequest, 1'b1);
      tick();
    end
    applyStimulus(0, 0, 1, 0, 0, 0);
    #2;
    checkOutput("t3_v_issue_read", s_read, 1'b1);
    checkOutput("t3_v_issue_wait", v_waitrequest, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();

    // Interleaved returns with a push and pop in the same cycle.
    k0 = k_rdv_cnt; v0 = v_rdv_cnt;
    k_address = 25'h200; k_burstcount = 5'd2; v_address = 25'h300; v_burstcount = 5'd3;
    applyStimulus(1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 1); tick();
    k_burstcount = 5'd1;
    applyStimulus(1, 0, 0, 0, 0, 1);
    #2;
    checkOutput("t4_pop_k", k_readdatavalid, 1'b1);
    checkOutput("t4_push_k", s_read, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    #2;
    checkOutput("t4_v_first", v_readdatavalid, 1'b1);
    repeat (4) tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("t4_k_beats", k_rdv_cnt - k0, 3);
    checkOutput("t4_v_beats", v_rdv_cnt - v0, 3);

    // Fill the owner FIFO, then free one slot.
    k_address = 25'h1234; k_burstcount = 5'd1;
    applyStimulus(1, 0, 0, 0, 0, 0); repeat (8) tick();
    #2;
    checkOutput("t5_full_s_read", s_read, 1'b0);
    checkOutput("t5_full_k_wait", k_waitrequest, 1'b1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1);
    #2;
    checkOutput("t5_pop_s_read", s_read, 1'b0);
    checkOutput("t5_pop_k_rdv", k_readdatavalid, 1'b1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    #2;
    checkOutput("t5_ninth_s_read", s_read, 1'b1);
    checkOutput("t5_ninth_k_wait", k_waitrequest, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1); repeat (8) tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();

    // Stray response sets a sticky error.
    applyStimulus(0, 0, 0, 0, 0, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("t6_err_set", err_rdv_unexpected, 1'b1);
    repeat (3) tick();
    checkOutput("t6_err_sticky", err_rdv_unexpected, 1'b1);

    // Reset in the middle of a write burst.
    k_burstcount = 5'd4; v_address = 25'h55; v_burstcount = 5'd1;
    applyStimulus(0, 1, 0, 0, 0, 0); tick();
    applyStimulus(0, 1, 1, 0, 0, 0);
    #2;
    checkOutput("t6_burst_v_wait", v_waitrequest, 1'b1);
    tick();
    reset_n = 1'b0;
    #2;
    checkOutput("t6_rst_s_write", s_write, 1'b0);
    checkOutput("t6_rst_k_wait", k_waitrequest, 1'b1);
    checkOutput("t6_rst_v_wait", v_waitrequest, 1'b1);
    tick();
    reset_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    #2;
    checkOutput("t6_rel_err", err_rdv_unexpected, 1'b0);
    checkOutput("t6_rel_s_read", s_read, 1'b1);
    checkOutput("t6_rel_v_wait", v_waitrequest, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
